seg_scan_driver: RTL

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_pkg.sv | 16 +
 rtl/hex_to_seg.sv | 11 +
 rtl/seg_scan_driver.sv | 104 ++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: segment lookup table
// (active-high, bit0 = a ... bit6 = g) and the all-segments-off pattern.
package seg_pkg;

  typedef logic [3:0] nibble_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'h00;

  // Index 0 sits in the least significant slice, so entry F is listed first.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-high seven-segment pattern.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] Nibble_i,
  output logic [6:0] Seg_o
);

  assign Seg_o = SEG_TABLE[Nibble_i];

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver. ScanClk is a slow data signal that
// is synchronised and edge-detected to step the digit index; the displayed
// value is double-buffered so a new value only appears at a frame boundary.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    ScanClk,
  input  logic [4*NUM_DIGITS-1:0] Value,
  input  logic                    ValueLoad,
  input  logic                    BlankLeading,
  input  logic [NUM_DIGITS-1:0]   DpMask,
  output logic [6:0]              Seg,
  output logic                    Dp,
  output logic [NUM_DIGITS-1:0]   An,
  output logic                    Frame
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic                    sync1_q, sync2_q, sync3_q;
  logic                    scan_tick;
  logic [IDX_W-1:0]        digit_idx_q;
  logic                    wrap;
  logic [4*NUM_DIGITS-1:0] pending_q, active_q;
  logic                    frame_q;
  logic [4*NUM_DIGITS-1:0] upper;
  logic [6:0]              hex_seg, seg_ah;
  logic                    blank;
  logic [6:0]              seg_q;
  logic                    dp_q;
  logic [NUM_DIGITS-1:0]   an_q;

  // Two-flop synchroniser plus a third stage for rising-edge detection.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= ScanClk;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign scan_tick = sync2_q & ~sync3_q;
  assign wrap      = scan_tick && (digit_idx_q == LAST_IDX);

  // Digit stepping, frame pulse and tear-free Pending -> Active handover.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      digit_idx_q <= '0;
      frame_q     <= 1'b0;
      pending_q   <= '0;
      active_q    <= '0;
    end else begin
      frame_q <= wrap;
      if (scan_tick)
        digit_idx_q <= wrap ? '0 : digit_idx_q + 1'b1;
      if (ValueLoad)
        pending_q <= Value;
      // A load landing on the wrap edge goes straight to the display.
      if (wrap)
        active_q <= ValueLoad ? Value : pending_q;
    end
  end

  // Shifting the current nibble to the bottom also exposes the nibbles above
  // it, which is exactly what leading-zero blanking needs to test.
  assign upper = active_q >> {digit_idx_q, 2'b00};
  assign blank = BlankLeading && (digit_idx_q != '0) && (upper == '0);

  hex_to_seg u_hex_to_seg (
    .Nibble_i (upper[3:0]),
    .Seg_o    (hex_seg)
  );

  assign seg_ah = blank ? SEG_OFF : hex_seg;

  // Registered pad drive; reset forces everything to the inactive level.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      seg_q <= SEG_OFF ^ {7{ACTIVE_LOW}};
      dp_q  <= ACTIVE_LOW;
      an_q  <= {NUM_DIGITS{ACTIVE_LOW}};
    end else begin
      seg_q <= seg_ah ^ {7{ACTIVE_LOW}};
      dp_q  <= DpMask[digit_idx_q] ^ ACTIVE_LOW;
      an_q  <= (NUM_DIGITS'(1) << digit_idx_q) ^ {NUM_DIGITS{ACTIVE_LOW}};
    end
  end

  assign Seg   = seg_q;
  assign Dp    = dp_q;
  assign An    = an_q;
  assign Frame = frame_q;

endmodule
